// File: rtl/mem_bus_responder_if.sv
// M_BUS request/response bundle between the controller (master) and the
// memory-side responder (slave).
interface mem_bus_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              MRD;
  logic              MWR;
  logic [ADDR_W-1:0] ADDR;
  logic [15:0]       W_BUS;
  logic [15:0]       M_BUS;
  logic              MRDY;
  logic              BUSY;

  modport master (
    output MRD, MWR, ADDR, W_BUS,
    input  M_BUS, MRDY, BUSY
  );

  modport slave (
    input  MRD, MWR, ADDR, W_BUS,
    output M_BUS, MRDY, BUSY
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder: 2^ADDR_W x 16 word memory serving single read/write
// requests with WAIT_CYCLES wait states, a one-cycle MRDY completion strobe
// and registered read data on M_BUS.
module mem_bus_responder #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] INIT_VALUE  = 16'b0
) (
  input  logic               CLK,
  input  logic               CLR,
  mem_bus_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              wr_q;
  logic [15:0]       m_bus_q;
  logic              mrdy_q;
  logic [15:0]       mem [2**ADDR_W];

  logic              accept;
  logic              enter_done;
  logic [ADDR_W-1:0] op_addr;
  logic [15:0]       op_wdata;
  logic              op_wr;

  // Next-state logic; a request is only looked at while IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MWR || bus.MRD) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) state_next = DONE;
          else                  state_next = WAIT;
        end
      end
      WAIT:    if (cnt == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // DONE is only ever reached from IDLE or WAIT, so this is the entry edge.
  assign enter_done = (state_next == DONE);

  // With zero wait states the access happens on the accept edge itself,
  // before the latches are loaded, so take the request straight from the bus.
  always_comb begin
    op_addr  = addr_q;
    op_wdata = wdata_q;
    op_wr    = wr_q;
    if (accept) begin
      op_addr  = bus.ADDR;
      op_wdata = bus.W_BUS;
      op_wr    = bus.MWR;
    end
  end

  // Control state, request latches, wait counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      mrdy_q  <= 1'b0;
      m_bus_q <= INIT_VALUE;
    end else begin
      state  <= state_next;
      mrdy_q <= enter_done;
      if (accept) begin
        addr_q  <= bus.ADDR;
        wdata_q <= bus.W_BUS;
        wr_q    <= bus.MWR;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !op_wr) m_bus_q <= mem[op_addr];
    end
  end

  // Memory array; not cleared by CLR, and CLR blocks a completing write.
  always_ff @(posedge CLK) begin
    if (!CLR && enter_done && op_wr) mem[op_addr] <= op_wdata;
  end

  assign bus.M_BUS = m_bus_q;
  assign bus.MRDY  = mrdy_q;
  assign bus.BUSY  = (state != IDLE);

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with 2 wait states and one with
// none, each checked cycle by cycle against a word-array reference model.
module tb_mem_bus_responder;

  localparam int unsigned WC0 = 2;
  localparam int unsigned WC1 = 0;

  logic CLK = 1'b0;
  logic clr0;
  logic clr1;
  always #5 CLK = ~CLK;

  mem_bus_responder_if #(.ADDR_W(8)) b0 ();
  mem_bus_responder_if #(.ADDR_W(8)) b1 ();

  mem_bus_responder #(.ADDR_W(8), .WAIT_CYCLES(WC0), .INIT_VALUE(16'h0000)) dut0 (
    .CLK(CLK), .CLR(clr0), .bus(b0)
  );
  mem_bus_responder #(.ADDR_W(8), .WAIT_CYCLES(WC1), .INIT_VALUE(16'h0000)) dut1 (
    .CLK(CLK), .CLR(clr1), .bus(b1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] ref_mem [2][256];
  logic [15:0] exp_mbus [2];
  logic [7:0]  wl0 [$];
  logic [7:0]  wl1 [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs(input int u);
    if (u == 0) return {b0.BUSY, b0.MRDY, b0.M_BUS};
    return {b1.BUSY, b1.MRDY, b1.M_BUS};
  endfunction

  task automatic drive(input int u, input bit wr, input bit rd, input logic [7:0] a, input logic [15:0] d);
    if (u == 0) begin
      b0.MWR = wr; b0.MRD = rd; b0.ADDR = a; b0.W_BUS = d;
    end else begin
      b1.MWR = wr; b1.MRD = rd; b1.ADDR = a; b1.W_BUS = d;
    end
  endtask

  // One transaction, entered and left at a negedge with the DUT idle. The
  // accept edge is the next posedge; BUSY must then hold for wc+1 cycles,
  // MRDY in the last of them only, and the DUT be idle again right after,
  // so the next call accepts exactly wc+2 edges after this one.
  task automatic xact(input int u, input bit wr, input bit rd, input logic [7:0] a, input logic [15:0] d);
    int unsigned wc;
    logic [17:0] o;
    wc = (u == 0) ? WC0 : WC1;
    o = obs(u);
    check_eq($sformatf("u%0d pre-accept busy", u), 32'(o[17]), 32'd0);
    drive(u, wr, rd, a, d);
    @(posedge CLK);
    if (wr) begin
      ref_mem[u][a] = d;
      if (u == 0) wl0.push_back(a); else wl1.push_back(a);
    end
    for (int unsigned k = 0; k <= wc; k++) begin
      @(negedge CLK);
      if (k == wc && !wr) exp_mbus[u] = ref_mem[u][a];
      o = obs(u);
      check_eq($sformatf("u%0d busy k%0d a%h", u, k, a), 32'(o[17]), 32'd1);
      check_eq($sformatf("u%0d mrdy k%0d a%h", u, k, a), 32'(o[16]), (k == wc) ? 32'd1 : 32'd0);
      check_eq($sformatf("u%0d m_bus k%0d a%h", u, k, a), 32'(o[15:0]), 32'(exp_mbus[u]));
      // Requests while busy (here an MRD to 8'h30 plus random junk) must be ignored.
      drive(u, 1'($urandom_range(0, 1)), 1'b1, 8'h30, 16'($urandom));
    end
    @(negedge CLK);
    o = obs(u);
    check_eq($sformatf("u%0d post busy a%h", u, a), 32'(o[17]), 32'd0);
    check_eq($sformatf("u%0d post mrdy a%h", u, a), 32'(o[16]), 32'd0);
    check_eq($sformatf("u%0d post m_bus a%h", u, a), 32'(o[15:0]), 32'(exp_mbus[u]));
    drive(u, 1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic pulse_clr(input int u);
    logic [17:0] o;
    if (u == 0) clr0 = 1'b1; else clr1 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    if (u == 0) clr0 = 1'b0; else clr1 = 1'b0;
    exp_mbus[u] = 16'h0000;
    o = obs(u);
    check_eq($sformatf("u%0d clr busy", u), 32'(o[17]), 32'd0);
    check_eq($sformatf("u%0d clr mrdy", u), 32'(o[16]), 32'd0);
    check_eq($sformatf("u%0d clr m_bus", u), 32'(o[15:0]), 32'd0);
  endtask

  // Write 16'hFFFF to 8'h07 on unit 0 and reset it in wait cycle kab.
  task automatic abort_write(input int unsigned kab);
    logic [17:0] o;
    drive(0, 1'b1, 1'b0, 8'h07, 16'hFFFF);
    @(posedge CLK);
    for (int unsigned k = 0; k <= kab; k++) begin
      @(negedge CLK);
      drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    clr0 = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    clr0 = 1'b0;
    exp_mbus[0] = 16'h0000;
    o = obs(0);
    check_eq($sformatf("abort k%0d busy", kab), 32'(o[17]), 32'd0);
    check_eq($sformatf("abort k%0d mrdy", kab), 32'(o[16]), 32'd0);
    xact(0, 1'b0, 1'b1, 8'h07, 16'h0000);
    check_eq($sformatf("abort k%0d mem kept", kab), 32'(exp_mbus[0]), 32'h0001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] o;
    logic [7:0]  a;
    clr0 = 1'b1;
    clr1 = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
    drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
    exp_mbus[0] = 16'h0000;
    exp_mbus[1] = 16'h0000;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    clr0 = 1'b0;
    clr1 = 1'b0;
    for (int u = 0; u < 2; u++) begin
      o = obs(u);
      check_eq($sformatf("u%0d reset busy", u), 32'(o[17]), 32'd0);
      check_eq($sformatf("u%0d reset mrdy", u), 32'(o[16]), 32'd0);
      check_eq($sformatf("u%0d reset m_bus", u), 32'(o[15:0]), 32'h0000);
    end

    // Memory survives CLR.
    xact(0, 1'b1, 1'b0, 8'h10, 16'hBEEF);
    pulse_clr(0);
    xact(0, 1'b0, 1'b1, 8'h10, 16'h0000);
    check_eq("beef after clr", 32'(exp_mbus[0]), 32'h0000BEEF);

    // Write then read; write leaves M_BUS alone.
    xact(0, 1'b1, 1'b0, 8'h05, 16'h1234);
    xact(0, 1'b0, 1'b1, 8'h05, 16'h0000);

    // MRD and MWR together is a write.
    xact(0, 1'b1, 1'b1, 8'h20, 16'hA5A5);
    xact(0, 1'b0, 1'b1, 8'h20, 16'h0000);

    // Aborted writes, in the first and in the last wait cycle.
    xact(0, 1'b1, 1'b0, 8'h07, 16'h0001);
    abort_write(0);
    abort_write(WC0 - 1);

    // Zero-wait unit: directed reads, then back-to-back reads of 0..3.
    xact(1, 1'b1, 1'b0, 8'h00, 16'h00FF);
    xact(1, 1'b0, 1'b1, 8'h00, 16'h0000);
    for (int i = 1; i < 4; i++) xact(1, 1'b1, 1'b0, 8'(i), 16'(16'h1100 + i));
    for (int i = 0; i < 4; i++) xact(1, 1'b0, 1'b1, 8'(i), 16'h0000);
    pulse_clr(1);
    xact(1, 1'b0, 1'b1, 8'h02, 16'h0000);

    // Randomized mix on both units; reads only target written words.
    for (int n = 0; n < 80; n++) begin
      int u;
      u = n % 2;
      if ($urandom_range(0, 2) == 0 || (u == 0 ? wl0.size() : wl1.size()) == 0) begin
        xact(u, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom));
      end else begin
        if (u == 0) a = wl0[$urandom_range(0, wl0.size() - 1)];
        else        a = wl1[$urandom_range(0, wl1.size() - 1)];
        xact(u, 1'b0, 1'b1, a, 16'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
